key_debounce: RTL and testbench

//   Conditions a raw asynchronous push-button/switch into the clean, clk-synchronous level that our

---
 rtl/key_debounce.sv | 163 ++++++++++++++++
 tb/tb_key_debounce.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: conditions a raw push-button into a clean clk-synchronous level
// with one-cycle press/release strobes.
// Build option: define KEY_DEBOUNCE_REPEAT_EN to enable the hold-to-repeat strobe
// on rpt. Without it, rpt is tied low and the REPEAT_* parameters only size the counter.
// The release strobe port is named release_pulse because `release` is a reserved word.
//
// state      | meaning
// IDLE       | key accepted as released, waiting for a synced 1
// PRESS_WAIT | synced 1 seen, counting stable samples before accepting a press
// HELD       | key accepted as pressed
// REL_WAIT   | synced 0 seen while held, counting stable samples before accepting release
module key_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic rpt
);

  localparam int MAX_SR = (STABLE_CYCLES > REPEAT_DELAY) ? STABLE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ALL = (MAX_SR > REPEAT_PERIOD) ? MAX_SR : REPEAT_PERIOD;
  localparam int CW = $clog2(MAX_ALL + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  logic          s1_q, s2_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Debounce FSM next-state: one transition per edge, strobes default low.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(STABLE_CYCLES)) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = REL_WAIT;
          cnt_d   = CW'(1);
        end
      end
      REL_WAIT: begin
        if (s2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CW'(STABLE_CYCLES)) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // Synchronizer, FSM state and registered outputs; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= key_raw;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  // Repeat timer is a down-counter: loaded with the initial delay on press,
  // reloaded with the period after every strobe, terminal count at 1.
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          rpt_q, rpt_d;

  // Repeat next-state: counts only while held; suppressed on the edge that leaves to IDLE.
  always_comb begin
    rcnt_d = rcnt_q;
    rpt_d  = 1'b0;
    if (press_d) begin
      rcnt_d = CW'(REPEAT_DELAY);
    end else if (release_d) begin
      rcnt_d = '0;
    end else if (state_q == HELD || state_q == REL_WAIT) begin
      if (rcnt_q <= CW'(1)) begin
        rpt_d  = 1'b1;
        rcnt_d = CW'(REPEAT_PERIOD);
      end else begin
        rcnt_d = rcnt_q - CW'(1);
      end
    end
  end

  // Repeat timer and strobe registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rcnt_q <= '0;
      rpt_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rpt_q  <= rpt_d;
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = 1'b0;
`endif

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenarios for key_debounce with a strobe scoreboard.
// Expected press/release/rpt events (kind and cycle) are queued as stimulus is
// driven; every observed strobe pops and compares the next expected event.
// Build with KEY_DEBOUNCE_REPEAT_EN defined to also expect repeat strobes.
module tb_key_debounce;

  logic clk = 1'b0;
  logic reset;
  logic key_raw;
  logic level, press, release_pulse, rpt;

  key_debounce #(
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_raw      (key_raw),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .rpt          (rpt)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] EV_PRESS = 2'd1;
  localparam logic [1:0] EV_REL   = 2'd2;
  localparam logic [1:0] EV_RPT   = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    int         at;
  } ev_t;

  ev_t sb_q[$];
  int  cyc;
  int  n_pass;
  int  n_total;
  int  n_fail;
  int  c;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    sb_q.push_back(e);
  endtask

  task automatic see(input logic [1:0] kind);
    ev_t e;
    if (sb_q.size() == 0) begin
      check("strobe_unexpected", 40'(kind), 40'(0));
    end else begin
      e = sb_q.pop_front();
      check("strobe_event", {6'b0, kind, 32'(cyc)}, {6'b0, e.kind, 32'(e.at)});
    end
  endtask

  // One clock: sample #1 after the edge, check strobe exclusivity and feed the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check("strobe_exclusive", 40'($countones({press, release_pulse, rpt}) <= 1), 40'(1));
    if (press) see(EV_PRESS);
    if (release_pulse) see(EV_REL);
    if (rpt) see(EV_RPT);
  endtask

  initial begin
    cyc     = 0;
    n_pass  = 0;
    n_total = 0;
    n_fail  = 0;
    reset   = 1'b0;
    key_raw = 1'b1;

    // Reset held with key pressed: everything stays low.
    repeat (3) begin
      tick();
      check("rst_level", 40'(level), 40'(0));
      check("rst_press", 40'(press), 40'(0));
      check("rst_release", 40'(release_pulse), 40'(0));
      check("rst_rpt", 40'(rpt), 40'(0));
    end

    // Release reset with key held: press after full latency.
    reset = 1'b1;
    c = cyc;
    expect_ev(EV_PRESS, c + 7);
    repeat (6) tick();
    check("lat_level_before", 40'(level), 40'(0));
    tick();
    check("lat_level_after", 40'(level), 40'(1));
    tick();
    check("press_one_cycle", 40'(press), 40'(0));
    check("held_level", 40'(level), 40'(1));

    // Mid-HELD reset: level drops, no release; fresh press after full latency.
    reset = 1'b0;
    tick();
    check("midrst_level", 40'(level), 40'(0));
    check("midrst_release", 40'(release_pulse), 40'(0));
    reset = 1'b1;
    c = cyc;
    expect_ev(EV_PRESS, c + 7);
`ifdef KEY_DEBOUNCE_REPEAT_EN
    for (int i = 20; i <= 60; i += 8) expect_ev(EV_RPT, c + 7 + i);
`endif
    repeat (7) tick();
    check("repress_level", 40'(level), 40'(1));
    repeat (60) tick();
    check("hold_level", 40'(level), 40'(1));
`ifndef KEY_DEBOUNCE_REPEAT_EN
    check("norpt_rpt", 40'(rpt), 40'(0));
`endif
    key_raw = 1'b0;
    expect_ev(EV_REL, cyc + 7);
    repeat (6) tick();
    check("rel_level_before", 40'(level), 40'(1));
    tick();
    check("rel_level_after", 40'(level), 40'(0));
    repeat (25) tick();
    check("idle_level", 40'(level), 40'(0));

    // Glitch of 4 raw cycles: rejected.
    key_raw = 1'b1;
    repeat (4) tick();
    key_raw = 1'b0;
    repeat (10) tick();
    check("glitch_level", 40'(level), 40'(0));

    // 5 raw cycles: just long enough to be accepted, then released.
    key_raw = 1'b1;
    c = cyc;
    expect_ev(EV_PRESS, c + 7);
    repeat (5) tick();
    key_raw = 1'b0;
    expect_ev(EV_REL, cyc + 7);
    repeat (12) tick();
    check("min_pulse_level", 40'(level), 40'(0));

    // Bounce on press: one press, timed from the final rise.
    key_raw = 1'b1; tick();
    key_raw = 1'b0; tick();
    key_raw = 1'b1; tick();
    key_raw = 1'b0; tick();
    key_raw = 1'b1;
    expect_ev(EV_PRESS, cyc + 7);
    repeat (9) tick();
    check("bounce_press_level", 40'(level), 40'(1));

    // Bounce on release: one release, timed from the final fall.
    key_raw = 1'b0; tick();
    key_raw = 1'b1; tick();
    key_raw = 1'b0; tick();
    key_raw = 1'b1; tick();
    key_raw = 1'b0;
    expect_ev(EV_REL, cyc + 7);
    repeat (6) tick();
    check("bounce_rel_level_before", 40'(level), 40'(1));
    repeat (6) tick();
    check("bounce_rel_level_after", 40'(level), 40'(0));

    check("sb_empty", 40'(sb_q.size()), 40'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
